riscv_i32_trace_nybble_packer: RTL and testbench

//  Successor stage to the trace compressor. It accepts variable-length compressed trace

---
 rtl/riscv_i32_trace_nybble_packer.sv | 174 +++++++++++++++++
 tb/tb_riscv_i32_trace_nybble_packer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_i32_trace_nybble_packer.sv
// riscv_i32_trace_nybble_packer
// Packs variable-length compressed trace entries (0..16 nybbles per cycle) into a
// nybble buffer and emits fixed-width words over a valid/ack handshake. Includes
// back-pressure, drop accounting and explicit or timeout-driven flush with padding.
// Invariant: buffer nybbles at positions >= level are always zero. Accepted data
// is therefore merged with a plain OR after a mask.
module riscv_i32_trace_nybble_packer #(
  parameter int         OUT_NYBBLES   = 8,
  parameter int         BUF_NYBBLES   = 32,
  parameter logic [3:0] PAD_NYBBLE    = 4'hF,
  parameter int         FLUSH_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [4:0]               compressed_trace__valid,
  input  logic [63:0]              compressed_trace__data,
  output logic                     in_ready,
  input  logic                     flush_req,
  output logic                     out_valid,
  input  logic                     out_ack,
  output logic [4*OUT_NYBBLES-1:0] out_data,
  output logic [4:0]               out_num_nybbles,
  output logic                     flushing,
  output logic                     overflow,
  output logic [7:0]               dropped_count
);

  localparam int LW = $clog2(BUF_NYBBLES + 1);
  localparam int BW = 4 * BUF_NYBBLES;
  localparam int TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [BW-1:0] BUF_ONES = {BW{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_FLUSHING = 1'b1
  } state_t;

  state_t                   state_r, state_nxt_s;
  logic [BW-1:0]            buf_r, buf_nxt_s;
  logic [LW-1:0]            level_r, level_nxt_s, base_s;
  logic [TW-1:0]            timer_r, timer_nxt_s;
  logic                     overflow_r;
  logic [7:0]               dropped_r;

  logic                     in_ready_s, out_valid_s;
  logic [4*OUT_NYBBLES-1:0] out_data_s;
  logic [4:0]               out_num_s;
  logic [4:0]               valid_clamp_s, pop_num_s;
  logic                     accept_s, drop_s, pop_s;
  logic                     timer_run_s, timer_fire_s;
  logic [63:0]              in_mask_s;
  logic [BW-1:0]            keep_mask_s, new_bits_s;

  // Output view derived purely from registered state (level, buffer, FSM).
  always_comb begin
    in_ready_s  = ((LW'(BUF_NYBBLES) - level_r) >= LW'(16)) && (state_r == ST_IDLE);
    out_valid_s = (level_r >= LW'(OUT_NYBBLES)) ||
                  ((state_r == ST_FLUSHING) && (level_r != {LW{1'b0}}));
    if (level_r >= LW'(OUT_NYBBLES)) begin
      out_num_s = 5'(OUT_NYBBLES);
    end else begin
      out_num_s = 5'(level_r);
    end
    out_data_s = {(4*OUT_NYBBLES){1'b0}};
    for (int i = 0; i < OUT_NYBBLES; i++) begin
      if (!out_valid_s) begin
        out_data_s[4*i +: 4] = 4'h0;
      end else if (LW'(i) < level_r) begin
        out_data_s[4*i +: 4] = buf_r[4*i +: 4];
      end else begin
        out_data_s[4*i +: 4] = PAD_NYBBLE;
      end
    end
  end

  // Accept/drop/pop decisions, buffer shift-and-merge and next level.
  always_comb begin
    if (compressed_trace__valid > 5'd16) begin
      valid_clamp_s = 5'd16;
    end else begin
      valid_clamp_s = compressed_trace__valid;
    end
    accept_s  = (valid_clamp_s != 5'd0) && in_ready_s;
    drop_s    = (valid_clamp_s != 5'd0) && !in_ready_s;
    pop_s     = out_valid_s && out_ack;
    pop_num_s = pop_s ? out_num_s : 5'd0;
    // base is where the new entry lands once this cycle's pop has shifted the buffer.
    base_s    = level_r - LW'(pop_num_s);
    if (accept_s) begin
      level_nxt_s = base_s + LW'(valid_clamp_s);
    end else begin
      level_nxt_s = base_s;
    end
    // Shifting by 64 bits (valid==16) yields zero, i.e. a full mask.
    in_mask_s   = ~(64'hFFFF_FFFF_FFFF_FFFF << {valid_clamp_s, 2'b00});
    new_bits_s  = BW'(compressed_trace__data & in_mask_s) << {base_s, 2'b00};
    keep_mask_s = ~(BUF_ONES << {base_s, 2'b00});
    if (accept_s) begin
      buf_nxt_s = ((buf_r >> {pop_num_s, 2'b00}) & keep_mask_s) | new_bits_s;
    end else begin
      buf_nxt_s = (buf_r >> {pop_num_s, 2'b00}) & keep_mask_s;
    end
  end

  // Idle timer: runs while a partial word sits untouched in IDLE.
  always_comb begin
    timer_run_s = (state_r == ST_IDLE) && (level_r != {LW{1'b0}}) &&
                  (level_r < LW'(OUT_NYBBLES)) && !accept_s;
    if (FLUSH_TIMEOUT != 0) begin
      timer_fire_s = timer_run_s && (timer_r == TW'(FLUSH_TIMEOUT - 1));
    end else begin
      timer_fire_s = 1'b0;
    end
    if (timer_run_s && !timer_fire_s) begin
      timer_nxt_s = timer_r + TW'(1);
    end else begin
      timer_nxt_s = {TW{1'b0}};
    end
  end

  // Flush FSM: only enter FLUSHING if something will remain to emit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((flush_req || timer_fire_s) && (level_nxt_s != {LW{1'b0}})) begin
          state_nxt_s = ST_FLUSHING;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FLUSHING: begin
        if (pop_s && (level_nxt_s == {LW{1'b0}})) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FLUSHING;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      buf_r      <= {BW{1'b0}};
      level_r    <= {LW{1'b0}};
      timer_r    <= {TW{1'b0}};
      overflow_r <= 1'b0;
      dropped_r  <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      buf_r   <= buf_nxt_s;
      level_r <= level_nxt_s;
      timer_r <= timer_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (dropped_r != 8'hFF) begin
          dropped_r <= dropped_r + 8'd1;
        end
      end
    end
  end

  assign in_ready        = in_ready_s;
  assign out_valid       = out_valid_s;
  assign out_data        = out_data_s;
  assign out_num_nybbles = out_num_s;
  assign flushing        = (state_r == ST_FLUSHING);
  assign overflow        = overflow_r;
  assign dropped_count   = dropped_r;

endmodule

// File: tb/tb_riscv_i32_trace_nybble_packer.sv
// Testbench for riscv_i32_trace_nybble_packer: directed vector table, timeout
// sequences, reset-while-busy, and random traffic against a queue-based model.
module tb_riscv_i32_trace_nybble_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  valid;
  logic [63:0] data;
  logic        flush_req, out_ack;

  logic        rdy_a, ov_a, fl_a, of_a;
  logic [31:0] od_a;
  logic [4:0]  on_a;
  logic [7:0]  dc_a;
  logic        rdy_b, ov_b, fl_b, of_b;
  logic [31:0] od_b;
  logic [4:0]  on_b;
  logic [7:0]  dc_b;
  logic        rdy_c, ov_c, fl_c, of_c;
  logic [31:0] od_c;
  logic [4:0]  on_c;
  logic [7:0]  dc_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_i32_trace_nybble_packer u_dut (
    .clk(clk), .reset_n(reset_n),
    .compressed_trace__valid(valid), .compressed_trace__data(data),
    .in_ready(rdy_a), .flush_req(flush_req), .out_valid(ov_a), .out_ack(out_ack),
    .out_data(od_a), .out_num_nybbles(on_a), .flushing(fl_a),
    .overflow(of_a), .dropped_count(dc_a));

  riscv_i32_trace_nybble_packer #(.FLUSH_TIMEOUT(16)) u_dut_t16 (
    .clk(clk), .reset_n(reset_n),
    .compressed_trace__valid(valid), .compressed_trace__data(data),
    .in_ready(rdy_b), .flush_req(flush_req), .out_valid(ov_b), .out_ack(out_ack),
    .out_data(od_b), .out_num_nybbles(on_b), .flushing(fl_b),
    .overflow(of_b), .dropped_count(dc_b));

  riscv_i32_trace_nybble_packer #(.FLUSH_TIMEOUT(0)) u_dut_t0 (
    .clk(clk), .reset_n(reset_n),
    .compressed_trace__valid(valid), .compressed_trace__data(data),
    .in_ready(rdy_c), .flush_req(flush_req), .out_valid(ov_c), .out_ack(out_ack),
    .out_data(od_c), .out_num_nybbles(on_c), .flushing(fl_c),
    .overflow(of_c), .dropped_count(dc_c));

  typedef struct {
    logic [4:0]  v;
    logic [63:0] d;
    logic        f;
    logic        a;
    logic        ev;
    logic [31:0] ed;
    logic [4:0]  en;
    logic        er;
    logic        ef;
    logic [7:0]  edc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid = 5'd0; data = 64'd0; flush_req = 1'b0; out_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic add(input logic [4:0] v, input logic [63:0] d, input logic f, input logic a,
                     input logic ev, input logic [31:0] ed, input logic [4:0] en,
                     input logic er, input logic ef, input logic [7:0] edc);
    vec_t r;
    r.v = v; r.d = d; r.f = f; r.a = a; r.ev = ev; r.ed = ed; r.en = en;
    r.er = er; r.ef = ef; r.edc = edc;
    tbl.push_back(r);
  endtask

  // Reference model state: a plain queue of buffered nybbles.
  logic [3:0] mq[$];
  bit         m_flush;
  int         m_idle_run;
  bit         m_ovf;
  int         m_drop;

  initial begin
    int f16, f64, f0;
    reset_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_in_ready", 64'(rdy_a), 64'd1);
    check("rst_out_valid", 64'(ov_a), 64'd0);
    check("rst_out_data", 64'(od_a), 64'd0);
    check("rst_num", 64'(on_a), 64'd0);
    check("rst_flushing", 64'(fl_a), 64'd0);
    check("rst_overflow", 64'(of_a), 64'd0);
    check("rst_dropped", 64'(dc_a), 64'd0);

    // Eight single-nybble entries fill one word
    for (int i = 0; i < 8; i++) begin
      add(5'd1, 64'(i), 1'b0, 1'b0, (i == 7), (i == 7) ? 32'h76543210 : 32'h0,
          5'(i + 1), 1'b1, 1'b0, 8'd0);
    end
    // Full entry with simultaneous pop, then drain
    add(5'd16, 64'hFEDCBA9876543210, 1'b0, 1'b1, 1'b1, 32'h76543210, 5'd8, 1'b1, 1'b0, 8'd0);
    add(5'd0, 64'd0, 1'b0, 1'b1, 1'b1, 32'hFEDCBA98, 5'd8, 1'b1, 1'b0, 8'd0);
    add(5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 8'd0);
    // Fill to full, third entry dropped, then drain
    add(5'd16, 64'h0123456789ABCDEF, 1'b0, 1'b0, 1'b1, 32'h89ABCDEF, 5'd8, 1'b1, 1'b0, 8'd0);
    add(5'd16, 64'hFEDCBA9876543210, 1'b0, 1'b0, 1'b1, 32'h89ABCDEF, 5'd8, 1'b0, 1'b0, 8'd0);
    add(5'd16, 64'h5555555555555555, 1'b0, 1'b0, 1'b1, 32'h89ABCDEF, 5'd8, 1'b0, 1'b0, 8'd1);
    add(5'd0, 64'd0, 1'b0, 1'b1, 1'b1, 32'h01234567, 5'd8, 1'b0, 1'b0, 8'd1);
    add(5'd0, 64'd0, 1'b0, 1'b1, 1'b1, 32'h76543210, 5'd8, 1'b1, 1'b0, 8'd1);
    add(5'd0, 64'd0, 1'b0, 1'b1, 1'b1, 32'hFEDCBA98, 5'd8, 1'b1, 1'b0, 8'd1);
    add(5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 8'd1);
    // Flush of an empty buffer does nothing
    add(5'd0, 64'd0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 8'd1);
    // Partial word flush with padding; input during flush is dropped
    add(5'd1, 64'h5, 1'b0, 1'b0, 1'b0, 32'h0, 5'd1, 1'b1, 1'b0, 8'd1);
    add(5'd1, 64'hA, 1'b0, 1'b0, 1'b0, 32'h0, 5'd2, 1'b1, 1'b0, 8'd1);
    add(5'd1, 64'h3, 1'b0, 1'b0, 1'b0, 32'h0, 5'd3, 1'b1, 1'b0, 8'd1);
    add(5'd0, 64'd0, 1'b1, 1'b0, 1'b1, 32'hFFFFF3A5, 5'd3, 1'b0, 1'b1, 8'd1);
    add(5'd1, 64'h7, 1'b1, 1'b0, 1'b1, 32'hFFFFF3A5, 5'd3, 1'b0, 1'b1, 8'd2);
    add(5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 8'd2);
    // valid > 16 is clamped to 16
    add(5'd20, 64'hCAFEBABEDEADBEEF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 5'd8, 1'b1, 1'b0, 8'd2);
    add(5'd0, 64'd0, 1'b0, 1'b1, 1'b1, 32'hCAFEBABE, 5'd8, 1'b1, 1'b0, 8'd2);
    add(5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 8'd2);

    for (int r = 0; r < tbl.size(); r++) begin
      valid = tbl[r].v; data = tbl[r].d; flush_req = tbl[r].f; out_ack = tbl[r].a;
      tick();
      idle_inputs();
      check($sformatf("vec%0d_out_valid", r), 64'(ov_a), 64'(tbl[r].ev));
      check($sformatf("vec%0d_out_data", r), 64'(od_a), 64'(tbl[r].ed));
      check($sformatf("vec%0d_num", r), 64'(on_a), 64'(tbl[r].en));
      check($sformatf("vec%0d_in_ready", r), 64'(rdy_a), 64'(tbl[r].er));
      check($sformatf("vec%0d_flushing", r), 64'(fl_a), 64'(tbl[r].ef));
      check($sformatf("vec%0d_dropped", r), 64'(dc_a), 64'(tbl[r].edc));
    end
    check("tbl_overflow_sticky", 64'(of_a), 64'd1);

    // Reset while a word is pending
    valid = 5'd12; data = 64'h0000BBBBAAAAAAAA;
    tick();
    idle_inputs();
    check("pre_rst_out_valid", 64'(ov_a), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_out_valid", 64'(ov_a), 64'd0);
    check("mid_rst_num", 64'(on_a), 64'd0);
    check("mid_rst_out_data", 64'(od_a), 64'd0);
    check("mid_rst_dropped", 64'(dc_a), 64'd0);
    check("mid_rst_overflow", 64'(of_a), 64'd0);
    check("mid_rst_in_ready", 64'(rdy_a), 64'd1);

    // Timeout flush: 2 nybbles then idle, three timeout settings
    do_reset();
    valid = 5'd2; data = 64'h21;
    tick();
    idle_inputs();
    f16 = -1; f64 = -1; f0 = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (fl_b && f16 < 0) f16 = k;
      if (fl_a && f64 < 0) f64 = k;
      if (fl_c && f0 < 0) f0 = k;
    end
    check("timeout16_cycle", 64'(f16), 64'(16));
    check("timeout64_cycle", 64'(f64), 64'(64));
    check("timeout0_never", 64'(f0), 64'(-1));
    check("timeout16_data", 64'(od_b), 64'hFFFFFF21);
    check("timeout16_num", 64'(on_b), 64'd2);

    // Random traffic against the queue model
    do_reset();
    mq.delete();
    m_flush = 1'b0; m_idle_run = 0; m_ovf = 1'b0; m_drop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int lvl, n, vc;
      bit rdy, ov, acc, drp, run, fire, quiet;
      logic [31:0] ed;
      logic [3:0] nyb;
      logic [63:0] exp_t, act_t;

      lvl = mq.size();
      rdy = (32 - lvl >= 16) && !m_flush;
      ov  = (lvl >= 8) || (m_flush && lvl > 0);
      n   = (lvl < 8) ? lvl : 8;
      ed  = 32'h0;
      if (ov) begin
        for (int j = 0; j < 8; j++) begin
          nyb = (j < lvl) ? mq[j] : 4'hF;
          ed = ed | (32'(nyb) << (4 * j));
        end
      end
      exp_t = {15'd0, ov, ed, 5'(n), rdy, m_flush, m_ovf, 8'(m_drop)};
      act_t = {15'd0, ov_a, od_a, on_a, rdy_a, fl_a, of_a, dc_a};
      check($sformatf("rand%0d", cyc), act_t, exp_t);

      quiet = (cyc % 400) >= 300;
      valid = (!quiet && $urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 20)) : 5'd0;
      data = {$urandom, $urandom};
      flush_req = !quiet && ($urandom_range(0, 31) == 0);
      out_ack = 1'($urandom_range(0, 1));

      vc  = (valid > 5'd16) ? 16 : int'(valid);
      acc = (vc != 0) && rdy;
      drp = (vc != 0) && !rdy;
      // A partial word left alone in IDLE for 64 consecutive cycles auto-flushes.
      run = !m_flush && lvl > 0 && lvl < 8 && !acc;
      if (run) m_idle_run++;
      else m_idle_run = 0;
      fire = run && (m_idle_run == 64);
      if (ov && out_ack) begin
        for (int j = 0; j < n; j++) void'(mq.pop_front());
      end
      if (acc) begin
        for (int j = 0; j < vc; j++) mq.push_back(4'(data >> (4 * j)));
      end
      if (drp) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if (!m_flush) begin
        if ((flush_req || fire) && mq.size() > 0) m_flush = 1'b1;
      end else if (ov && out_ack && mq.size() == 0) begin
        m_flush = 1'b0;
      end
      if (m_flush) m_idle_run = 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
